sd_spi: RTL and testbench

- SPI master for the SD card, directly downstream of the top-level port controller.
- Consumes the one-cycle command pulse, 2-bit control code and command byte that the controller latches on CPU writes to ports 0x2C/0x2D.
- Drives SD_CLK, SD_CMD (MOSI) and SD_DATA[3] (CS_n); samples SD_DATA[0] (MISO).
- Returns the received byte plus busy status for the controller to map back into the CPU read mux.

---
 rtl/sd_spi_pkg.sv | 26 ++
 rtl/sd_spi_if.sv | 25 ++
 rtl/sd_spi_tick.sv | 46 ++++
 rtl/sd_spi.sv | 181 ++++++++++++++++++
 tb/tb_sd_spi.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared definitions for the SD-card SPI master.
//   spi_cmd_e : 2-bit control codes latched by the port controller
//   state_e   : transfer sequencer states
//   DEF_*     : default divider / preamble constants (25 MHz system clock)
package sd_spi_pkg;

    typedef enum logic [1:0] {
        SPI_PUT  = 2'd0,
        SPI_INIT = 2'd1,
        SPI_CE0  = 2'd2,
        SPI_CE1  = 2'd3
    } spi_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_INIT,
        ST_FIN
    } state_e;

    localparam int unsigned DIV_W         = 8;
    localparam int unsigned DEF_DIV_FAST  = 1;   // 25 MHz / 4  = 6.25 MHz
    localparam int unsigned DEF_DIV_SLOW  = 31;  // 25 MHz / 64 ~ 390 kHz
    localparam int unsigned DEF_INIT_CLKS = 80;

endpackage

// File: rtl/sd_spi_if.sv
// sd_spi_if: command/status bus between the port controller and sd_spi.
//   start : one-cycle command strobe       ctl  : command code
//   din   : byte to transmit (PUT)         fast : divider select for PUT
//   busy  : transfer in progress           done : one-cycle end-of-command pulse
//   dout  : last received byte
// master = controller side, slave = sd_spi side.
interface sd_spi_if;
    logic       start;
    logic [1:0] ctl;
    logic [7:0] din;
    logic       fast;
    logic       busy;
    logic       done;
    logic [7:0] dout;

    modport master (
        output start, ctl, din, fast,
        input  busy, done, dout
    );

    modport slave (
        input  start, ctl, din, fast,
        output busy, done, dout
    );
endinterface

// File: rtl/sd_spi_tick.sv
// sd_spi_tick: loadable down-counter that emits a one-cycle tick every
// div+1 enabled clocks. The divider is captured on load so later changes
// on div do not affect a running transfer.
//   clock, reset : system clock, synchronous active-high reset
//   load         : restart counter with div (command accepted)
//   div          : half-period minus one, in clocks
//   en           : count enable (transfer active)
//   tick         : one-cycle pulse, toggles SCK
module sd_spi_tick
    import sd_spi_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            div_d = div;
            cnt_d = div;
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
        end
    end

    assign tick = en && (cnt_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sd_spi.sv
// sd_spi: SPI mode-0 master (MSB first) for the SD card.
//   clock, reset : 25 MHz system clock, synchronous active-high reset
//   bus          : controller command/status bus (sd_spi_if.slave)
//   sd_clk       : SCK, idles low
//   sd_mosi      : MOSI, idles high, changes only while SCK is low
//   sd_miso      : MISO, sampled on the clock SCK rises
//   sd_cs_n      : chip select, active low
// Commands: PUT shifts one byte, INIT emits INIT_CLKS slow pulses with CS_n
// and MOSI high, CE0/CE1 drive CS_n low/high. Every command ends in a
// one-cycle FIN state with done asserted; FIN may accept the next start.
module sd_spi
    import sd_spi_pkg::*;
#(
    parameter int unsigned DIV_FAST  = DEF_DIV_FAST,
    parameter int unsigned DIV_SLOW  = DEF_DIV_SLOW,
    parameter int unsigned INIT_CLKS = DEF_INIT_CLKS
) (
    input  logic     clock,
    input  logic     reset,
    sd_spi_if.slave  bus,
    output logic     sd_clk,
    output logic     sd_mosi,
    input  logic     sd_miso,
    output logic     sd_cs_n
);

    localparam logic [DIV_W-1:0] DIV_F     = DIV_W'(DIV_FAST);
    localparam logic [DIV_W-1:0] DIV_S     = DIV_W'(DIV_SLOW);
    localparam logic [7:0]       INIT_LAST = 8'(INIT_CLKS - 1);

    state_e      state_q, state_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  cnt_q, cnt_d;      // falling edges (PUT) or pulses (INIT)

    logic             accept;
    logic [DIV_W-1:0] div_sel;
    logic             tick;

    assign accept  = bus.start && (state_q == ST_IDLE || state_q == ST_FIN);
    assign div_sel = (bus.ctl == SPI_PUT && bus.fast) ? DIV_F : DIV_S;

    sd_spi_tick u_tick (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .div   (div_sel),
        .en    (state_q == ST_SHIFT || state_q == ST_INIT),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (accept) begin
                    sck_d = 1'b0;
                    cnt_d = '0;
                    case (bus.ctl)
                        SPI_PUT: begin
                            state_d = ST_SHIFT;
                            busy_d  = 1'b1;
                            tx_d    = bus.din;
                            mosi_d  = bus.din[7];
                        end
                        SPI_INIT: begin
                            state_d = ST_INIT;
                            busy_d  = 1'b1;
                            cs_n_d  = 1'b1;
                            mosi_d  = 1'b1;
                        end
                        SPI_CE0: begin
                            state_d = ST_FIN;
                            cs_n_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                        default: begin
                            state_d = ST_FIN;
                            cs_n_d  = 1'b1;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            ST_SHIFT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[6:0], sd_miso};
                    end else begin
                        sck_d = 1'b0;
                        if (cnt_q == 8'd7) begin
                            // 8th falling edge: no further shift, MOSI back to idle
                            state_d = ST_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            dout_d  = rx_q;
                            mosi_d  = 1'b1;
                        end else begin
                            cnt_d  = cnt_q + 1'b1;
                            tx_d   = {tx_q[6:0], 1'b1};
                            mosi_d = tx_q[6];
                        end
                    end
                end
            end

            ST_INIT: begin
                if (tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (cnt_q == INIT_LAST) begin
                            state_d = ST_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            dout_d  = 8'hFF;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= 8'hFF;
            tx_q    <= '1;
            rx_q    <= '1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sd_clk   = sck_q;
    assign sd_mosi  = mosi_q;
    assign sd_cs_n  = cs_n_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dout = dout_q;

endmodule

// File: tb/tb_sd_spi.sv
// tb_sd_spi: directed bench for sd_spi with a cycle-level reference model.
// The model tracks each command as "busy cycle k of N" and derives SCK,
// MOSI, busy, done, CS_n and dout arithmetically from k and the divider.
module tb_sd_spi;
    import sd_spi_pkg::*;

    localparam int TB_DF = 1;
    localparam int TB_DS = 3;
    localparam int TB_IC = 80;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic sd_clk, sd_mosi, sd_miso, sd_cs_n;
    logic loop_en  = 1'b1;
    logic miso_drv = 1'b1;
    assign sd_miso = loop_en ? sd_mosi : miso_drv;

    sd_spi_if bus_if ();

    sd_spi #(
        .DIV_FAST  (TB_DF),
        .DIV_SLOW  (TB_DS),
        .INIT_CLKS (TB_IC)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus_if.slave),
        .sd_clk  (sd_clk),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso),
        .sd_cs_n (sd_cs_n)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode = 0;     // 0 none, 1 PUT, 2 INIT
    int         m_k = 0, m_d = 0, m_total = 0;
    logic [7:0] m_tx = 8'hFF, m_rx_exp = 8'hFF, m_dout = 8'hFF, m_resp = 8'hFF;
    logic       m_cs = 1'b1, m_done = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_mode = 0; m_k = 0; m_cs = 1'b1; m_dout = 8'hFF; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_mode != 0) begin
                if (m_k == m_total) begin
                    m_done = 1'b1;
                    m_dout = (m_mode == 1) ? m_rx_exp : 8'hFF;
                    m_mode = 0;
                end else begin
                    m_k++;
                end
            end else if (bus_if.start) begin
                case (bus_if.ctl)
                    2'd0: begin
                        m_mode = 1; m_k = 1;
                        m_d = bus_if.fast ? TB_DF : TB_DS;
                        m_total = 16 * (m_d + 1);
                        m_tx = bus_if.din;
                        m_rx_exp = loop_en ? bus_if.din : m_resp;
                    end
                    2'd1: begin
                        m_mode = 2; m_k = 1; m_d = TB_DS;
                        m_total = 2 * TB_IC * (m_d + 1);
                        m_cs = 1'b1;
                    end
                    2'd2: begin m_cs = 1'b0; m_done = 1'b1; end
                    default: begin m_cs = 1'b1; m_done = 1'b1; end
                endcase
            end
        end
    end

    // ---------------- compare process ----------------
    logic chk_en = 1'b0;
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_clk, exp_mosi;
            exp_clk  = (m_mode != 0) && ((((m_k - 1) / (m_d + 1)) % 2) == 1);
            exp_mosi = (m_mode == 1) ? m_tx[7 - ((m_k - 1) / (2 * (m_d + 1)))] : 1'b1;
            check("busy",    32'(bus_if.busy), 32'(m_mode != 0));
            check("done",    32'(bus_if.done), 32'(m_done));
            check("sd_clk",  32'(sd_clk),      32'(exp_clk));
            check("sd_mosi", 32'(sd_mosi),     32'(exp_mosi));
            check("sd_cs_n", 32'(sd_cs_n),     32'(m_cs));
            check("dout",    32'(bus_if.dout), 32'(m_dout));
        end
        miso_drv = (m_mode == 1) ? m_resp[7 - ((m_k - 1) / (2 * (m_d + 1)))] : 1'b1;
    end

    // ---------------- edge / pulse monitors ----------------
    logic       prev_clk = 1'b0;
    int         rise_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] mon_mosi = '0;
    always @(negedge clock) begin
        if (sd_clk === 1'b1 && prev_clk === 1'b0) begin
            rise_cnt++;
            mon_mosi = {mon_mosi[6:0], sd_mosi};
        end
        prev_clk = sd_clk;
        if (bus_if.done === 1'b1) done_cnt++;
    end

    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic f);
        @(posedge clock); #1;
        bus_if.start = 1'b1; bus_if.ctl = c; bus_if.din = d; bus_if.fast = f;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
    endtask

    // Returns the cycle (counted from the accepting edge) in which done is seen.
    task automatic wait_done(input int max, output int lat);
        lat = 0;
        for (int n = 1; n <= max; n++) begin
            if (n > 1) @(posedge clock);
            @(negedge clock);
            if (bus_if.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus_if.start = 1'b0; bus_if.ctl = 2'd0; bus_if.din = 8'h00; bus_if.fast = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;

        // 1: idle after reset
        repeat (10) @(posedge clock);
        @(negedge clock);
        check("rst_sd_clk", 32'(sd_clk), 32'h0);
        check("rst_mosi",   32'(sd_mosi), 32'h1);
        check("rst_cs_n",   32'(sd_cs_n), 32'h1);
        check("rst_busy",   32'(bus_if.busy), 32'h0);
        check("rst_dout",   32'(bus_if.dout), 32'hFF);

        // 2: chip-enable commands
        issue(2'd2, 8'h00, 1'b0);
        wait_done(10, lat);
        check("ce0_lat",  32'(lat), 32'd1);
        check("ce0_cs_n", 32'(sd_cs_n), 32'h0);
        issue(2'd3, 8'h00, 1'b0);
        wait_done(10, lat);
        check("ce1_lat",  32'(lat), 32'd1);
        check("ce1_cs_n", 32'(sd_cs_n), 32'h1);

        // 3: fast PUT A5 with loopback
        loop_en = 1'b1; rise_cnt = 0;
        issue(2'd0, 8'hA5, 1'b1);
        wait_done(100, lat);
        check("put_fast_lat",  32'(lat), 32'd33);
        check("put_fast_dout", 32'(bus_if.dout), 32'hA5);
        check("put_fast_mosi", 32'(mon_mosi), 32'hA5);
        check("put_fast_rise", 32'(rise_cnt), 32'd8);

        // 4: slow PUT 81, card answers 3C; fast toggled mid-transfer
        loop_en = 1'b0; m_resp = 8'h3C; rise_cnt = 0;
        issue(2'd0, 8'h81, 1'b0);
        fork
            wait_done(200, lat);
            begin repeat (20) @(posedge clock); #1 bus_if.fast = 1'b1; end
        join
        check("put_slow_lat",  32'(lat), 32'd65);
        check("put_slow_dout", 32'(bus_if.dout), 32'h3C);
        check("put_slow_mosi", 32'(mon_mosi), 32'h81);

        // 5: INIT after CE0; a second start mid-INIT must be ignored
        loop_en = 1'b1;
        issue(2'd2, 8'h00, 1'b0);
        wait_done(10, lat);
        rise_cnt = 0;
        issue(2'd1, 8'h00, 1'b0);
        fork
            wait_done(2000, lat);
            begin
                repeat (100) @(posedge clock); #1;
                bus_if.start = 1'b1; bus_if.ctl = 2'd0; bus_if.din = 8'h00;
                @(posedge clock); #1 bus_if.start = 1'b0;
            end
        join
        check("init_lat",  32'(lat), 32'd641);
        check("init_rise", 32'(rise_cnt), 32'd80);
        check("init_cs_n", 32'(sd_cs_n), 32'h1);
        check("init_dout", 32'(bus_if.dout), 32'hFF);

        // 6: reset in the middle of a PUT
        issue(2'd2, 8'h00, 1'b0);
        wait_done(10, lat);
        issue(2'd0, 8'hC3, 1'b1);
        wait_done(100, lat);
        check("pre_rst_dout", 32'(bus_if.dout), 32'hC3);
        issue(2'd0, 8'h96, 1'b1);
        repeat (9) @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", 32'(bus_if.busy), 32'h0);
        check("midrst_clk",  32'(sd_clk), 32'h0);
        check("midrst_mosi", 32'(sd_mosi), 32'h1);
        check("midrst_cs_n", 32'(sd_cs_n), 32'h1);
        check("midrst_dout", 32'(bus_if.dout), 32'hFF);
        done_cnt = 0;
        repeat (40) @(negedge clock);
        check("midrst_no_done", 32'(done_cnt), 32'd0);

        issue(2'd2, 8'h00, 1'b0);
        wait_done(10, lat);
        issue(2'd0, 8'h5A, 1'b1);
        wait_done(100, lat);
        check("put_5a_lat",  32'(lat), 32'd33);
        check("put_5a_dout", 32'(bus_if.dout), 32'h5A);

        // start during the FIN cycle is accepted
        bus_if.start = 1'b1; bus_if.ctl = 2'd3;
        @(posedge clock); #1 bus_if.start = 1'b0;
        @(negedge clock);
        check("fin_start_done", 32'(bus_if.done), 32'h1);
        check("fin_start_cs_n", 32'(sd_cs_n), 32'h1);

        repeat (5) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
